// File: rtl/bitwise_sched_pkg.sv
// Shared types and sizing helpers for the bitwise operation scheduler.
// Provides the FSM state enum, default parameters and width helpers.
package bitwise_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_LATENCY = 10;

    // Width of a requester index (never below one bit).
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the latency down-counter.
    function automatic int cnt_w(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set bit of req at or after ptr.
// Ports: req (requests), ptr (priority start index), gnt (one-hot grant).
module rr_arbiter
    import bitwise_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int            s;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        s     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // Walk the ring starting at ptr, wrapping modulo N.
            s = int'(ptr) + i;
            if (s >= N) begin
                s = s - N;
            end
            idx = PW'(s);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitwise_op_sched.sv
// Round-robin scheduler in front of one shared multi-cycle AND/OR/XOR unit.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b
// per requester (operands packed at [i*WIDTH +: WIDTH]); rsp_valid,
// rsp_ready, rsp_id, rsp_and, rsp_or, rsp_xor response; busy status.
// Macro BITWISE_SCHED_FAST_ISSUE_EN: re-arbitrate in DONE on handshake.
module bitwise_op_sched
    import bitwise_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int LATENCY = DEF_LATENCY,
    localparam int IDW     = id_w(NUM_REQ),
    localparam int CW      = cnt_w(LATENCY)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_and,
    output logic [WIDTH-1:0]         rsp_or,
    output logic [WIDTH-1:0]         rsp_xor,
    output logic                     busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] and_q, or_q, xor_q;
    logic             load_res;

    logic [NUM_REQ-1:0] gnt;
    logic               grant_en;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [IDW-1:0]     sel_id;

    rr_arbiter #(
        .N   (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Grants are masked during reset so nothing looks accepted while
    // the block is being cleared.
`ifdef BITWISE_SCHED_FAST_ISSUE_EN
    assign grant_en = rst_n
                    & ((state_q == IDLE)
                    | ((state_q == DONE) & rsp_ready));
`else
    assign grant_en = rst_n & (state_q == IDLE);
`endif

    assign req_ready = grant_en ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        load_res = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            BUSY: begin
                // Leave BUSY on the edge where the count reaches zero.
                if (cnt_q <= CW'(1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    load_res = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept only happens in IDLE or in DONE on handshake, so it
        // safely overrides the transition chosen above.
        if (accept) begin
            a_d   = sel_a;
            b_d   = sel_b;
            id_d  = sel_id;
            cnt_d = CW'(LATENCY - 1);
            if (sel_id == IDW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel_id + IDW'(1);
            end
            if (LATENCY == 1) begin
                state_d  = DONE;
                load_res = 1'b1;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            if (load_res) begin
                and_q <= a_d & b_d;
                or_q  <= a_d | b_d;
                xor_q <= a_d ^ b_d;
            end
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_and   = and_q;
    assign rsp_or    = or_q;
    assign rsp_xor   = xor_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/bitwise_op_sched.md
Name: bitwise_op_sched

Overview:
- Round-robin scheduler sharing one multi-cycle bitwise logic unit (AND/OR/XOR of two operands) between NUM_REQ requesters.
- Arbitrates, captures one requester's operand pair and models the unit's fixed LATENCY-cycle compute time.
- Returns all three results tagged with the requester ID over a valid/ready response port.
- Sits between requesting client blocks and the shared bitwise datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 16, operand/result width.
- LATENCY, 10, cycles from accept to rsp_valid (>=1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of served requester.
- rsp_and  out  WIDTH  a & b.
- rsp_or  out  WIDTH  a | b.
- rsp_xor  out  WIDTH  a ^ b.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values: state IDLE; rr pointer 0; counter 0; rsp_valid 0; rsp_id 0; rsp_and/rsp_or/rsp_xor 0; busy 0.
- req_ready is combinational. In IDLE (or DONE with fast issue, see Optional Feature) it is the one-hot grant of the rr arbiter over req_valid; otherwise 0.
- Round-robin:
  - Search starts at rr pointer and wraps modulo NUM_REQ.
  - On accept of requester i, pointer becomes (i+1) mod NUM_REQ.
  - After reset, requester 0 has top priority.
- Accept = req_valid[i] & req_ready[i] at edge T:
  - captures req_a/req_b slice and ID;
  - loads counter with LATENCY-1.
- States:
  - IDLE: accept -> BUSY if LATENCY>1, else DONE. No request -> stay.
  - BUSY: counter decrements each cycle; reaches 0 -> DONE.
  - DONE: rsp_valid=1; results computed from captured operands and registered. rsp_valid rises at T+LATENCY. Outputs held stable while rsp_ready=0. Handshake (rsp_valid & rsp_ready) -> IDLE and rsp_valid clears next cycle.
- Requests arriving while busy are not accepted. Requesters hold req_valid and operands until their req_ready; the block neither drops nor queues them.
- Requester deasserting req_valid before grant: legal, no effect.
- Simultaneous requests: exactly one granted per the rr order.
- rsp_ready stuck low: block stalls in DONE indefinitely, no overflow, busy=1.
- Reset mid-operation: everything returns to reset values immediately (async); the in-flight result is discarded.
- Results are bit-exact for all widths; no arithmetic or width growth.

Optional Feature:
- Macro: BITWISE_SCHED_FAST_ISSUE_EN.
- Defined: in DONE with rsp_ready=1, the arbiter also grants in the same cycle. A new accept goes directly to BUSY/DONE (counter reloaded), so back-to-back issue interval is LATENCY cycles. busy stays 1; rsp_valid drops for LATENCY-1 cycles (stays high if LATENCY=1, with new data).
- Undefined: DONE always returns to IDLE first; req_ready is 0 in DONE; issue interval is LATENCY+1 cycles.

Decomposition:
- Package bitwise_sched_pkg:
  - state enum {IDLE, BUSY, DONE};
  - localparam helpers for ID width and counter width ($clog2(LATENCY)+1).
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt), reused by other shared-resource blocks.
- The bitwise compute stays inline.

Test Plan:
- Reset, then single request on req 2 with a=16'hF0F0, b=16'hFF00 at T -> rsp_valid at T+10 with rsp_id=2, and=16'hF000, or=16'hFFF0, xor=16'h0FF0.
- All 4 req_valid held high continuously -> grant order 0,1,2,3,0; each served once per rotation.
- rsp_ready held low 5 cycles after rsp_valid -> outputs and rsp_id stable, no req_ready pulses, busy=1; released -> IDLE next cycle.
- rst_n dropped at T+4 of an operation -> rsp_valid/busy/req_ready 0 immediately. After release, a new request gives a correct result and requester 0 is highest priority.
- LATENCY=1 build, req 1 a=16'hAAAA b=16'h5555 -> next cycle rsp_valid, and=0000, or=FFFF, xor=FFFF.
- BITWISE_SCHED_FAST_ISSUE_EN defined, req 0 and 1 held, rsp_ready=1 -> accepts 10 cycles apart (11 when macro undefined).
